captura_comandos_teclado: RTL and testbench

- Sits directly downstream of the PS/2 keyboard controller. Consumes its ASCII code stream plus a one-cycle key strobe.
- Parses short keyboard command sequences: a field letter, up to NDIG decimal digits, then Enter.
- Emits a committed packed-BCD value, a field identifier and a one-cycle commit tick to the time-setting/register logic.
- Also exposes the live entry buffer so the VGA overlay can echo digits while the user types.

---
 rtl/captura_comandos_teclado_pkg.sv | 53 +++++
 rtl/captura_comandos_teclado_clasificador.sv | 45 ++++
 rtl/captura_comandos_teclado.sv | 191 +++++++++++++++++++
 tb/tb_captura_comandos_teclado.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/captura_comandos_teclado_pkg.sv
// ---------------------------------------------------------------------------
// captura_comandos_teclado_pkg
// Shared definitions for the keyboard command capture block:
//   - ASCII codes of the keys the parser recognises
//   - FSM state encoding
//   - field codes (hours / minutes / seconds)
//   - per-field upper limits, used only when RANGE_CHECK_EN is defined
// ---------------------------------------------------------------------------
package captura_comandos_teclado_pkg;

  // Control keys
  localparam logic [7:0] ASCII_ENTER   = 8'h0D;
  localparam logic [7:0] ASCII_BKSP    = 8'h08;
  localparam logic [7:0] ASCII_ESC     = 8'h1B;

  // Digit range; the low nibble of '0'..'9' is already the BCD digit
  localparam logic [7:0] ASCII_DIGIT_0 = 8'h30;
  localparam logic [7:0] ASCII_DIGIT_9 = 8'h39;

  // Field letters, both cases
  localparam logic [7:0] ASCII_H_UP    = 8'h48;
  localparam logic [7:0] ASCII_H_LO    = 8'h68;
  localparam logic [7:0] ASCII_M_UP    = 8'h4D;
  localparam logic [7:0] ASCII_M_LO    = 8'h6D;
  localparam logic [7:0] ASCII_S_UP    = 8'h53;
  localparam logic [7:0] ASCII_S_LO    = 8'h73;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ENTRY = 1'b1
  } state_t;

  typedef logic [1:0] field_t;

  localparam field_t FLD_H = 2'd0;
  localparam field_t FLD_M = 2'd1;
  localparam field_t FLD_S = 2'd2;

  // Two-digit packed-BCD limits. Packed BCD orders the same way as binary,
  // so a plain unsigned compare is a valid decimal range check.
  localparam logic [7:0] LIM_H = 8'h23;
  localparam logic [7:0] LIM_M = 8'h59;
  localparam logic [7:0] LIM_S = 8'h59;

  function automatic logic [7:0] field_limit(input field_t fld);
    case (fld)
      FLD_H:   field_limit = LIM_H;
      FLD_M:   field_limit = LIM_M;
      default: field_limit = LIM_S;
    endcase
  endfunction

endpackage

// File: rtl/captura_comandos_teclado_clasificador.sv
// ---------------------------------------------------------------------------
// clasificador_ascii
// Purely combinational key classifier. Decodes one ASCII code into the key
// classes the command parser cares about. Codes outside every class leave
// all flags low, which the parser treats as "ignore".
// Ports:
//   i_code      ASCII code from the keyboard controller
//   o_is_digit  '0'..'9'
//   o_is_field  H/h, M/m or S/s
//   o_field_id  field code for the letter (FLD_H when not a letter)
//   o_is_enter  Enter
//   o_is_bksp   Backspace
//   o_is_esc    Esc
// ---------------------------------------------------------------------------
module clasificador_ascii
  import captura_comandos_teclado_pkg::*;
(
  input  logic [7:0] i_code,
  output logic       o_is_digit,
  output logic       o_is_field,
  output field_t     o_field_id,
  output logic       o_is_enter,
  output logic       o_is_bksp,
  output logic       o_is_esc
);

  assign o_is_digit = (i_code >= ASCII_DIGIT_0) && (i_code <= ASCII_DIGIT_9);
  assign o_is_enter = (i_code == ASCII_ENTER);
  assign o_is_bksp  = (i_code == ASCII_BKSP);
  assign o_is_esc   = (i_code == ASCII_ESC);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    o_is_field = 1'b0;
    o_field_id = FLD_H;
    case (i_code)
      ASCII_H_UP, ASCII_H_LO: begin o_is_field = 1'b1; o_field_id = FLD_H; end
      ASCII_M_UP, ASCII_M_LO: begin o_is_field = 1'b1; o_field_id = FLD_M; end
      ASCII_S_UP, ASCII_S_LO: begin o_is_field = 1'b1; o_field_id = FLD_S; end
      default: ;
    endcase
  end

endmodule

// File: rtl/captura_comandos_teclado.sv
// ---------------------------------------------------------------------------
// captura_comandos_teclado
// Parses keyboard command sequences "<field letter> <up to NDIG digits>
// <Enter>" from the PS/2 controller's ASCII stream and commits a packed-BCD
// value plus field id to the time-setting logic. The live entry buffer is
// exposed so the VGA overlay can echo digits as they are typed.
//
// Optional build macro RANGE_CHECK_EN (NDIG must be 2): commits over the
// field limit (H>23, M>59, S>59) pulse error_tick instead of commit_tick and
// leave value_out/field_out untouched. Without it error_tick is tied to 0.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   ascii_code   ASCII code, valid only with ascii_tick
//   ascii_tick   one-cycle keystroke strobe
//   field_out    committed field (0=H, 1=M, 2=S)
//   value_out    committed packed-BCD value, right-aligned
//   commit_tick  one-cycle pulse when field_out/value_out update
//   error_tick   one-cycle pulse on a rejected commit
//   busy         high while an entry is open
//   live_digits  current entry buffer
//   live_count   digits currently in the buffer
// ---------------------------------------------------------------------------
module captura_comandos_teclado
  import captura_comandos_teclado_pkg::*;
#(
  parameter int NDIG = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                ascii_code,
  input  logic                      ascii_tick,
  output logic [1:0]                field_out,
  output logic [4*NDIG-1:0]         value_out,
  output logic                      commit_tick,
  output logic                      error_tick,
  output logic                      busy,
  output logic [4*NDIG-1:0]         live_digits,
  output logic [$clog2(NDIG+1)-1:0] live_count
);

  localparam int                CW      = $clog2(NDIG + 1);
  localparam logic [CW-1:0]     MAX_CNT = CW'(NDIG);
  localparam logic [4*NDIG-1:0] BUF_ZERO = '0;

  // Key classification
  logic   w_is_digit;
  logic   w_is_field;
  field_t w_field_id;
  logic   w_is_enter;
  logic   w_is_bksp;
  logic   w_is_esc;

  clasificador_ascii u_clasificador (
    .i_code     (ascii_code),
    .o_is_digit (w_is_digit),
    .o_is_field (w_is_field),
    .o_field_id (w_field_id),
    .o_is_enter (w_is_enter),
    .o_is_bksp  (w_is_bksp),
    .o_is_esc   (w_is_esc)
  );

  // State
  state_t            r_state;
  logic [4*NDIG-1:0] r_buf;
  logic [CW-1:0]     r_cnt;
  field_t            r_field;

  // Next-state / decision signals
  state_t            w_state_next;
  logic [4*NDIG-1:0] w_buf_next;
  logic [CW-1:0]     w_cnt_next;
  field_t            w_field_next;
  logic              w_commit;
  logic              w_reject;
  logic              w_over_limit;

`ifdef RANGE_CHECK_EN
  assign w_over_limit = (r_buf > field_limit(r_field));
`else
  assign w_over_limit = 1'b0;
`endif

  // State register
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state and datapath decisions
  always_comb begin
    w_state_next = r_state;
    w_buf_next   = r_buf;
    w_cnt_next   = r_cnt;
    w_field_next = r_field;
    w_commit     = 1'b0;
    w_reject     = 1'b0;

    if (ascii_tick) begin
      case (r_state)
        ST_IDLE: begin
          if (w_is_field) begin
            w_field_next = w_field_id;
            w_buf_next   = BUF_ZERO;
            w_cnt_next   = '0;
            w_state_next = ST_ENTRY;
          end
        end

        ST_ENTRY: begin
          if (w_is_field) begin
            // A new letter mid-entry restarts the entry on that field.
            w_field_next = w_field_id;
            w_buf_next   = BUF_ZERO;
            w_cnt_next   = '0;
          end else if (w_is_digit) begin
            // Full buffer: extra digits are dropped rather than wrapping.
            if (r_cnt < MAX_CNT) begin
              w_buf_next      = r_buf << 4;
              w_buf_next[3:0] = ascii_code[3:0];
              w_cnt_next      = r_cnt + 1'b1;
            end
          end else if (w_is_bksp) begin
            if (r_cnt != '0) begin
              w_buf_next = r_buf >> 4;
              w_cnt_next = r_cnt - 1'b1;
            end
          end else if (w_is_esc) begin
            w_buf_next   = BUF_ZERO;
            w_cnt_next   = '0;
            w_state_next = ST_IDLE;
          end else if (w_is_enter) begin
            // Enter on an empty buffer keeps the entry open.
            if (r_cnt != '0) begin
              w_commit     = !w_over_limit;
              w_reject     = w_over_limit;
              w_buf_next   = BUF_ZERO;
              w_cnt_next   = '0;
              w_state_next = ST_IDLE;
            end
          end
        end

        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // Entry buffer, committed outputs and pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_buf       <= '0;
      r_cnt       <= '0;
      r_field     <= FLD_H;
      field_out   <= FLD_H;
      value_out   <= '0;
      commit_tick <= 1'b0;
      busy        <= 1'b0;
    end else begin
      r_buf       <= w_buf_next;
      r_cnt       <= w_cnt_next;
      r_field     <= w_field_next;
      commit_tick <= w_commit;
      // Registered from the next state so busy tracks r_state exactly.
      busy        <= (w_state_next == ST_ENTRY);
      if (w_commit) begin
        field_out <= r_field;
        value_out <= r_buf;
      end
    end
  end

`ifdef RANGE_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) error_tick <= 1'b0;
    else       error_tick <= w_reject;
  end
`else
  logic w_reject_unused;
  assign w_reject_unused = w_reject;
  assign error_tick      = 1'b0;
`endif

  assign live_digits = r_buf;
  assign live_count  = r_cnt;

endmodule

// File: tb/tb_captura_comandos_teclado.sv
module tb_captura_comandos_teclado;

  localparam int NDIG = 2;

  logic       clk;
  logic       reset;
  logic [7:0] ascii_code;
  logic       ascii_tick;
  logic [1:0] field_out;
  logic [7:0] value_out;
  logic       commit_tick;
  logic       error_tick;
  logic       busy;
  logic [7:0] live_digits;
  logic [1:0] live_count;

  captura_comandos_teclado #(.NDIG(NDIG)) dut (
    .clk         (clk),
    .reset       (reset),
    .ascii_code  (ascii_code),
    .ascii_tick  (ascii_tick),
    .field_out   (field_out),
    .value_out   (value_out),
    .commit_tick (commit_tick),
    .error_tick  (error_tick),
    .busy        (busy),
    .live_digits (live_digits),
    .live_count  (live_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  typedef struct {
    logic [7:0] code;
    int         gap;
    logic       commit;
    logic       busy;
    logic [1:0] cnt;
    logic [7:0] live;
    logic [1:0] fld;
    logic [7:0] val;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [7:0] code, input int gap, input logic commit,
                              input logic bsy, input logic [1:0] cnt, input logic [7:0] live,
                              input logic [1:0] fld, input logic [7:0] val);
    vec_t v;
    v.code = code; v.gap = gap; v.commit = commit; v.busy = bsy;
    v.cnt = cnt; v.live = live; v.fld = fld; v.val = val;
    return v;
  endfunction

  // One keystroke: tick high for exactly one cycle, driven at negedge. While
  // the tick is low, ascii_code carries a field letter that must be ignored.
  task automatic send_key(input logic [7:0] code);
    @(negedge clk);
    ascii_code = code;
    ascii_tick = 1'b1;
    @(negedge clk);
    ascii_tick = 1'b0;
    ascii_code = 8'h48;
  endtask

  // Sends a key then checks every output in the cycle after the tick, and
  // checks that any pulse is gone one cycle later.
  task automatic key_and_check(input string tag, input logic [7:0] code,
                               input logic e_commit, input logic e_error, input logic e_busy,
                               input logic [1:0] e_cnt, input logic [7:0] e_live,
                               input logic [1:0] e_fld, input logic [7:0] e_val);
    send_key(code);
    check({tag, ".commit_tick"}, commit_tick, e_commit);
    check({tag, ".error_tick"},  error_tick,  e_error);
    check({tag, ".busy"},        busy,        e_busy);
    check({tag, ".live_count"},  live_count,  e_cnt);
    check({tag, ".live_digits"}, live_digits, e_live);
    check({tag, ".field_out"},   field_out,   e_fld);
    check({tag, ".value_out"},   value_out,   e_val);
    @(negedge clk);
    check({tag, ".commit_width"}, commit_tick, 1'b0);
    check({tag, ".error_width"},  error_tick,  1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".commit_tick"}, commit_tick, 1'b0);
    check({tag, ".error_tick"},  error_tick,  1'b0);
    check({tag, ".busy"},        busy,        1'b0);
    check({tag, ".live_count"},  live_count,  2'd0);
    check({tag, ".live_digits"}, live_digits, 8'h00);
    check({tag, ".field_out"},   field_out,   2'd0);
    check({tag, ".value_out"},   value_out,   8'h00);
  endtask

  initial begin
    // code, gap, commit, busy, cnt, live, field_out, value_out
    // H 1 5 Enter, keys 20 cycles apart
    vecs.push_back(mk(8'h48, 20, 0, 1, 0, 8'h00, 0, 8'h00));
    vecs.push_back(mk(8'h31, 20, 0, 1, 1, 8'h01, 0, 8'h00));
    vecs.push_back(mk(8'h35, 20, 0, 1, 2, 8'h15, 0, 8'h00));
    vecs.push_back(mk(8'h0D, 20, 1, 0, 0, 8'h00, 0, 8'h15));
    // M 4 5 7(full, ignored) Bksp 9 Enter
    vecs.push_back(mk(8'h4D, 3, 0, 1, 0, 8'h00, 0, 8'h15));
    vecs.push_back(mk(8'h34, 3, 0, 1, 1, 8'h04, 0, 8'h15));
    vecs.push_back(mk(8'h35, 3, 0, 1, 2, 8'h45, 0, 8'h15));
    vecs.push_back(mk(8'h37, 3, 0, 1, 2, 8'h45, 0, 8'h15));
    vecs.push_back(mk(8'h08, 3, 0, 1, 1, 8'h04, 0, 8'h15));
    vecs.push_back(mk(8'h39, 3, 0, 1, 2, 8'h49, 0, 8'h15));
    vecs.push_back(mk(8'h0D, 3, 1, 0, 0, 8'h00, 1, 8'h49));
    // S 3 Esc, then Enter and 8 in IDLE are ignored
    vecs.push_back(mk(8'h53, 2, 0, 1, 0, 8'h00, 1, 8'h49));
    vecs.push_back(mk(8'h33, 2, 0, 1, 1, 8'h03, 1, 8'h49));
    vecs.push_back(mk(8'h1B, 2, 0, 0, 0, 8'h00, 1, 8'h49));
    vecs.push_back(mk(8'h0D, 2, 0, 0, 0, 8'h00, 1, 8'h49));
    vecs.push_back(mk(8'h38, 2, 0, 0, 0, 8'h00, 1, 8'h49));
    // H, Enter/Bksp on empty buffer, unknown key, restart with lowercase m
    vecs.push_back(mk(8'h48, 1, 0, 1, 0, 8'h00, 1, 8'h49));
    vecs.push_back(mk(8'h0D, 1, 0, 1, 0, 8'h00, 1, 8'h49));
    vecs.push_back(mk(8'h08, 1, 0, 1, 0, 8'h00, 1, 8'h49));
    vecs.push_back(mk(8'h41, 1, 0, 1, 0, 8'h00, 1, 8'h49));
    vecs.push_back(mk(8'h6D, 1, 0, 1, 0, 8'h00, 1, 8'h49));
    vecs.push_back(mk(8'h32, 1, 0, 1, 1, 8'h02, 1, 8'h49));
    vecs.push_back(mk(8'h0D, 1, 1, 0, 0, 8'h00, 1, 8'h02));
    // h 1 then s restarts mid-entry, 6 Enter
    vecs.push_back(mk(8'h68, 1, 0, 1, 0, 8'h00, 1, 8'h02));
    vecs.push_back(mk(8'h31, 1, 0, 1, 1, 8'h01, 1, 8'h02));
    vecs.push_back(mk(8'h73, 1, 0, 1, 0, 8'h00, 1, 8'h02));
    vecs.push_back(mk(8'h36, 1, 0, 1, 1, 8'h06, 1, 8'h02));
    vecs.push_back(mk(8'h0D, 1, 1, 0, 0, 8'h00, 2, 8'h06));

    ascii_code = 8'h48;
    ascii_tick = 1'b0;
    reset      = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("post_reset");

    foreach (vecs[i]) begin
      repeat (vecs[i].gap) @(negedge clk);
      key_and_check($sformatf("vec%0d", i), vecs[i].code, vecs[i].commit, 1'b0,
                    vecs[i].busy, vecs[i].cnt, vecs[i].live, vecs[i].fld, vecs[i].val);
    end

    // S 7 Enter on consecutive cycles
    @(negedge clk);
    ascii_code = 8'h53; ascii_tick = 1'b1;
    @(negedge clk);
    check("b2b.busy_after_S", busy, 1'b1);
    ascii_code = 8'h37;
    @(negedge clk);
    check("b2b.count_after_7", live_count, 2'd1);
    check("b2b.live_after_7",  live_digits, 8'h07);
    ascii_code = 8'h0D;
    @(negedge clk);
    ascii_tick = 1'b0; ascii_code = 8'h48;
    check("b2b.commit_tick", commit_tick, 1'b1);
    check("b2b.field_out",   field_out,   2'd2);
    check("b2b.value_out",   value_out,   8'h07);
    check("b2b.busy",        busy,        1'b0);
    @(negedge clk);
    check("b2b.commit_width", commit_tick, 1'b0);

`ifdef RANGE_CHECK_EN
    key_and_check("rc.H",   8'h48, 0, 0, 1, 0, 8'h00, 2, 8'h07);
    key_and_check("rc.1",   8'h31, 0, 0, 1, 1, 8'h01, 2, 8'h07);
    key_and_check("rc.5",   8'h35, 0, 0, 1, 2, 8'h15, 2, 8'h07);
    key_and_check("rc.ok",  8'h0D, 1, 0, 0, 0, 8'h00, 0, 8'h15);
    key_and_check("rc.M",   8'h4D, 0, 0, 1, 0, 8'h00, 0, 8'h15);
    key_and_check("rc.2",   8'h32, 0, 0, 1, 1, 8'h02, 0, 8'h15);
    key_and_check("rc.4",   8'h34, 0, 0, 1, 2, 8'h24, 0, 8'h15);
    key_and_check("rc.h",   8'h48, 0, 0, 1, 0, 8'h00, 0, 8'h15);
    key_and_check("rc.2b",  8'h32, 0, 0, 1, 1, 8'h02, 0, 8'h15);
    key_and_check("rc.4b",  8'h34, 0, 0, 1, 2, 8'h24, 0, 8'h15);
    key_and_check("rc.err", 8'h0D, 0, 1, 0, 0, 8'h00, 0, 8'h15);
    key_and_check("rc.H23", 8'h48, 0, 0, 1, 0, 8'h00, 0, 8'h15);
    key_and_check("rc.2c",  8'h32, 0, 0, 1, 1, 8'h02, 0, 8'h15);
    key_and_check("rc.3c",  8'h33, 0, 0, 1, 2, 8'h23, 0, 8'h15);
    key_and_check("rc.lim", 8'h0D, 1, 0, 0, 0, 8'h00, 0, 8'h23);
`else
    key_and_check("nr.H",   8'h48, 0, 0, 1, 0, 8'h00, 2, 8'h07);
    key_and_check("nr.2",   8'h32, 0, 0, 1, 1, 8'h02, 2, 8'h07);
    key_and_check("nr.4",   8'h34, 0, 0, 1, 2, 8'h24, 2, 8'h07);
    key_and_check("nr.ent", 8'h0D, 1, 0, 0, 0, 8'h00, 0, 8'h24);
`endif

    // H 2, async reset mid-entry, then 3 Enter must not commit
    key_and_check("rst.H", 8'h48, 0, 0, 1, 0, 8'h00, field_out, value_out);
    key_and_check("rst.2", 8'h32, 0, 0, 1, 1, 8'h02, field_out, value_out);
    #2 reset = 1'b1;
    #1 check_all_zero("rst.during");
    @(negedge clk);
    check_all_zero("rst.held");
    reset = 1'b0;
    key_and_check("rst.3",   8'h33, 0, 0, 0, 0, 8'h00, 0, 8'h00);
    key_and_check("rst.ent", 8'h0D, 0, 0, 0, 0, 8'h00, 0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
